pls_onchip_mem_arbiter: RTL and testbench

//  Shares the single-port 4x32 on-chip RAM between two Avalon-MM masters (m0, m1).

---
 rtl/pls_mem_arb_pkg.sv | 10 +
 rtl/pls_rr_arb2.sv | 38 +++
 rtl/pls_onchip_mem_arbiter.sv | 91 +++++++++
 tb/tb_pls_onchip_mem_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pls_mem_arb_pkg.sv
// Shared widths and master indices for the on-chip RAM arbiter.
package pls_mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 2;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/pls_rr_arb2.sv
// Two-way round-robin grant; grant is combinational, last_q remembers the last winner.
module pls_rr_arb2
  import pls_mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic freeze,
  input  logic req0,
  input  logic req1,
  output logic gnt_valid,
  output logic gnt_idx
);

  logic last_q;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = M0;
    if (!freeze) begin
      gnt_valid = req0 | req1;
      if (req0 && req1) begin
        // Whoever did not win last time wins the contention.
        gnt_idx = (last_q == M1) ? M0 : M1;
      end else if (req1) begin
        gnt_idx = M1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= M1;
    end else if (gnt_valid) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/pls_onchip_mem_arbiter.sv
// Shares a single-port on-chip RAM between two Avalon-MM masters with round-robin grant.
module pls_onchip_mem_arbiter
  import pls_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                freeze,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic       req0, req1;
  logic       gnt_valid, gnt_idx;
  logic       gnt0, gnt1;
  logic [1:0] rdv_q;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  pls_rr_arb2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .freeze    (freeze),
    .req0      (req0),
    .req1      (req1),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign gnt0 = gnt_valid && (gnt_idx == M0);
  assign gnt1 = gnt_valid && (gnt_idx == M1);

  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    mem_write      = gnt0 & m0_write;
    if (gnt1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end
  end

  assign mem_chipselect = gnt_valid;
  assign mem_clken      = 1'b1;

  assign m0_waitrequest = req0 & ~gnt0;
  assign m1_waitrequest = req1 & ~gnt1;

  // A simultaneous write wins over read, so such a transfer produces no return pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdv_q <= '0;
    end else begin
      rdv_q[0] <= gnt0 & m0_read & ~m0_write;
      rdv_q[1] <= gnt1 & m1_read & ~m1_write;
    end
  end

  assign m0_readdatavalid = rdv_q[0];
  assign m1_readdatavalid = rdv_q[1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_pls_onchip_mem_arbiter.sv
// Directed + randomized bench for the two-master RAM arbiter with a behavioural scoreboard.
module tb_pls_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        freeze;
  logic [1:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [1:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pls_onchip_mem_arbiter #(.ADDR_W(2), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .freeze(freeze),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // RAM stand-in: synchronous single-port 4x32 with byte lanes, one cycle read latency.
  logic [31:0] ram [4];
  initial for (int i = 0; i < 4; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // Scoreboard: who wins the next contention, expected contents, expected return pulses.
  int          pref = 0;
  logic [31:0] mirror [4] = '{default: '0};
  logic        exp_rdv [2] = '{1'b0, 1'b0};
  logic [31:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic fr,
                      input logic r0, input logic w0, input logic [1:0] a0,
                      input logic [3:0] b0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [1:0] a1,
                      input logic [3:0] b1, input logic [31:0] d1);
    logic        rq [2];
    logic        rd [2];
    logic        wr [2];
    logic [1:0]  ad [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];
    int g;
    freeze = fr;
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = b0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = b1; m1_writedata = d1;
    rd = '{r0, r1}; wr = '{w0, w1}; ad = '{a0, a1}; be = '{b0, b1}; wd = '{d0, d1};
    rq = '{r0 | w0, r1 | w1};
    g = -1;
    if (!fr) begin
      if (rq[0] && rq[1]) g = pref;
      else if (rq[0]) g = 0;
      else if (rq[1]) g = 1;
    end
    #2;
    chk("m0_waitrequest", {31'd0, m0_waitrequest}, {31'd0, rq[0] && g != 0});
    chk("m1_waitrequest", {31'd0, m1_waitrequest}, {31'd0, rq[1] && g != 1});
    chk("mem_chipselect", {31'd0, mem_chipselect}, {31'd0, g >= 0});
    if (g >= 0) begin
      chk("mem_address", {30'd0, mem_address}, {30'd0, ad[g]});
      chk("mem_write", {31'd0, mem_write}, {31'd0, wr[g]});
      if (wr[g]) begin
        chk("mem_writedata", mem_writedata, wd[g]);
        chk("mem_byteenable", {28'd0, mem_byteenable}, {28'd0, be[g]});
      end
    end
    chk("m0_readdatavalid", {31'd0, m0_readdatavalid}, {31'd0, exp_rdv[0]});
    chk("m1_readdatavalid", {31'd0, m1_readdatavalid}, {31'd0, exp_rdv[1]});
    if (exp_rdv[0]) chk("m0_readdata", m0_readdata, exp_rdata);
    if (exp_rdv[1]) chk("m1_readdata", m1_readdata, exp_rdata);
    @(posedge clk);
    exp_rdv = '{1'b0, 1'b0};
    if (g >= 0) begin
      pref = 1 - g;
      if (wr[g]) begin
        for (int b = 0; b < 4; b++)
          if (be[g][b]) mirror[ad[g]][8*b +: 8] = wd[g][8*b +: 8];
      end else if (rd[g]) begin
        exp_rdv[g] = 1'b1;
        exp_rdata  = mirror[ad[g]];
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    freeze = 1'b0;
    m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_rdv0", {31'd0, m0_readdatavalid}, 32'd0);
    chk("reset_rdv1", {31'd0, m1_readdatavalid}, 32'd0);
    chk("reset_chipselect", {31'd0, mem_chipselect}, 32'd0);
    chk("reset_wait0", {31'd0, m0_waitrequest}, 32'd0);
    chk("mem_clken", {31'd0, mem_clken}, 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Write then read the same word from the other master.
    step(1'b0, 1'b0, 1'b1, 2'd1, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0);
    idle();

    // Both masters read continuously: alternating grants.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b0, 2'(i), 4'h0, 32'h0, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0);
    idle();
    idle();

    // Partial byte-lane write over all-ones, then read back.
    step(1'b0, 1'b0, 1'b1, 2'd2, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 2'd2, 4'b0011, 32'h12345678, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
    chk("partial_write_word", m0_readdata, 32'hFFFF5678);
    idle();

    // Read+write together performs the write only.
    step(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 1'b1, 2'd3, 4'hF, 32'hA5A5_0F0F);
    step(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 1'b0, 2'd3, 4'h0, 32'h0);
    idle();

    // Freeze while a read is still returning.
    step(1'b0, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0);
    idle();

    // Make m0 the most recent winner, then reset right after an accepted read.
    step(1'b0, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
    m0_read = 1'b0;
    reset_n = 1'b0;
    #2;
    chk("reset_drops_rdv0", {31'd0, m0_readdatavalid}, 32'd0);
    chk("reset_drops_rdv1", {31'd0, m1_readdatavalid}, 32'd0);
    exp_rdv = '{1'b0, 1'b0};
    pref = 0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0);
    idle();

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      logic fr, r0, w0, r1, w1;
      fr = ($urandom_range(0, 9) == 0);
      r0 = ($urandom_range(0, 2) == 0);
      w0 = ($urandom_range(0, 3) == 0);
      r1 = ($urandom_range(0, 2) == 0);
      w1 = ($urandom_range(0, 3) == 0);
      step(fr, r0, w0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom,
           r1, w1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
